// File: rtl/uart_rgb_cmd_pkg.sv
// Shared constants and helpers for the UART RGB command decoder:
// FSM encodings, ASCII codes, channel indices and hex parsing.
package uart_rgb_cmd_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_HI   = 3'd1;
  localparam logic [2:0] ST_GET_LO   = 3'd2;
  localparam logic [2:0] ST_GET_TERM = 3'd3;
  localparam logic [2:0] ST_SEND     = 3'd4;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;
  localparam logic [7:0] ASCII_G_UC = 8'h47;
  localparam logic [7:0] ASCII_G_LC = 8'h67;
  localparam logic [7:0] ASCII_B_UC = 8'h42;
  localparam logic [7:0] ASCII_B_LC = 8'h62;

  localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;

  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Letters A-F/a-f all have bit 6 set and low nibble 1..6, so add 9.
  function automatic logic [3:0] hex_to_nibble(input logic [7:0] b);
    return b[3:0] + (b[6] ? 4'd9 : 4'd0);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_rgb_cmd_pwm_if.sv
// simpleuart register-port bundle between the command decoder (master)
// and the UART (slave).
interface uart_rgb_cmd_pwm_if;

  logic        reg_dat_re;
  logic [31:0] reg_dat_do;
  logic        reg_dat_we;
  logic [31:0] reg_dat_di;
  logic        reg_dat_wait;

  modport master (
    output reg_dat_re,
    input  reg_dat_do,
    output reg_dat_we,
    output reg_dat_di,
    input  reg_dat_wait
  );

  modport slave (
    input  reg_dat_re,
    output reg_dat_do,
    input  reg_dat_we,
    input  reg_dat_di,
    output reg_dat_wait
  );

endinterface

// File: rtl/rgb_pwm_gen.sv
// Three-channel 8-bit PWM: a shared prescaler and tick counter compared
// against each duty value, outputs registered on every tick.
module rgb_pwm_gen #(
  parameter int unsigned PWM_PRESCALE = 47
) (
  input  logic       hw_clk,
  input  logic       resetn,
  input  logic [7:0] duty_red,
  input  logic [7:0] duty_green,
  input  logic [7:0] duty_blue,
  output logic       pwm_red,
  output logic       pwm_green,
  output logic       pwm_blue
);

  localparam int unsigned PS_W = (PWM_PRESCALE > 0) ? $clog2(PWM_PRESCALE + 1) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PWM_PRESCALE);
  localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);
  localparam logic [PS_W-1:0] PS_ZERO = PS_W'(0);

  logic [PS_W-1:0] presc_r;
  logic [7:0]      cnt_r;
  logic            tick_s;
  logic            pwm_red_r;
  logic            pwm_green_r;
  logic            pwm_blue_r;

  assign tick_s = (presc_r == PS_MAX);

  // Prescaler, tick counter and compare registers; a duty change lands
  // at the next tick, and a same-cycle change still sees the old value.
  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      presc_r     <= PS_ZERO;
      cnt_r       <= 8'h00;
      pwm_red_r   <= 1'b0;
      pwm_green_r <= 1'b0;
      pwm_blue_r  <= 1'b0;
    end else if (tick_s) begin
      presc_r     <= PS_ZERO;
      cnt_r       <= cnt_r + 8'd1;
      pwm_red_r   <= (cnt_r < duty_red);
      pwm_green_r <= (cnt_r < duty_green);
      pwm_blue_r  <= (cnt_r < duty_blue);
    end else begin
      presc_r     <= presc_r + PS_ONE;
    end
  end

  assign pwm_red   = pwm_red_r;
  assign pwm_green = pwm_green_r;
  assign pwm_blue  = pwm_blue_r;

endmodule

// File: rtl/uart_rgb_cmd_pwm.sv
// Polls the simpleuart receive register, parses "<ch><hex><hex><CR|LF>"
// frames into per-colour duty registers, echoes ACK/NAK and drives RGB PWM.
module uart_rgb_cmd_pwm
  import uart_rgb_cmd_pkg::*;
#(
  parameter int unsigned PWM_PRESCALE = 47,
  parameter logic [7:0]  RESET_DUTY_R = 8'h00,
  parameter logic [7:0]  RESET_DUTY_G = 8'h00,
  parameter logic [7:0]  RESET_DUTY_B = 8'h00,
  parameter logic [7:0]  ACK_CHAR     = 8'h4B,
  parameter logic [7:0]  NAK_CHAR     = 8'h3F
) (
  input  logic                 hw_clk,
  input  logic                 resetn,
  uart_rgb_cmd_pwm_if.master   bus,
  output logic                 pwm_red,
  output logic                 pwm_green,
  output logic                 pwm_blue,
  output logic                 frame_err
);

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [1:0]  chan_r;
  logic [1:0]  chan_nxt_s;
  logic [3:0]  hi_r;
  logic [3:0]  hi_nxt_s;
  logic [3:0]  lo_r;
  logic [3:0]  lo_nxt_s;
  logic        re_r;
  logic [7:0]  byte_r;
  logic        byte_vld_r;
  logic        we_r;
  logic [31:0] di_r;
  logic        frame_err_r;
  logic        ack_s;
  logic        nak_s;
  logic        commit_s;
  logic        accept_s;
  logic        rx_state_s;
  logic [7:0]  duty_red_r;
  logic [7:0]  duty_green_r;
  logic [7:0]  duty_blue_r;

  assign rx_state_s = (state_r != ST_SEND);
  assign accept_s   = (state_r == ST_SEND) && we_r && !bus.reg_dat_wait;

  // Frame parser: decides the next state from the byte captured last cycle.
  always_comb begin
    state_nxt_s = state_r;
    chan_nxt_s  = chan_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    ack_s       = 1'b0;
    nak_s       = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!byte_vld_r) begin
          state_nxt_s = ST_IDLE;
        end else if ((byte_r == ASCII_R_UC) || (byte_r == ASCII_R_LC)) begin
          chan_nxt_s  = CH_RED;
          state_nxt_s = ST_GET_HI;
        end else if ((byte_r == ASCII_G_UC) || (byte_r == ASCII_G_LC)) begin
          chan_nxt_s  = CH_GREEN;
          state_nxt_s = ST_GET_HI;
        end else if ((byte_r == ASCII_B_UC) || (byte_r == ASCII_B_LC)) begin
          chan_nxt_s  = CH_BLUE;
          state_nxt_s = ST_GET_HI;
        end else if (is_eol(byte_r)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          nak_s       = 1'b1;
          state_nxt_s = ST_SEND;
        end
      end
      ST_GET_HI: begin
        if (!byte_vld_r) begin
          state_nxt_s = ST_GET_HI;
        end else if (is_hex(byte_r)) begin
          hi_nxt_s    = hex_to_nibble(byte_r);
          state_nxt_s = ST_GET_LO;
        end else begin
          nak_s       = 1'b1;
          state_nxt_s = ST_SEND;
        end
      end
      ST_GET_LO: begin
        if (!byte_vld_r) begin
          state_nxt_s = ST_GET_LO;
        end else if (is_hex(byte_r)) begin
          lo_nxt_s    = hex_to_nibble(byte_r);
          state_nxt_s = ST_GET_TERM;
        end else begin
          nak_s       = 1'b1;
          state_nxt_s = ST_SEND;
        end
      end
      ST_GET_TERM: begin
        if (!byte_vld_r) begin
          state_nxt_s = ST_GET_TERM;
        end else if (is_eol(byte_r)) begin
          commit_s    = 1'b1;
          ack_s       = 1'b1;
          state_nxt_s = ST_SEND;
        end else begin
          nak_s       = 1'b1;
          state_nxt_s = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, frame fields and receive handshake; a read is only issued when
  // nothing is in flight so each buffered byte is consumed exactly once.
  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      chan_r     <= CH_RED;
      hi_r       <= 4'h0;
      lo_r       <= 4'h0;
      re_r       <= 1'b0;
      byte_r     <= 8'h00;
      byte_vld_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      chan_r     <= chan_nxt_s;
      hi_r       <= hi_nxt_s;
      lo_r       <= lo_nxt_s;
      re_r       <= rx_state_s && !re_r && !byte_vld_r && (bus.reg_dat_do != UART_EMPTY);
      byte_vld_r <= re_r;
      if (re_r) begin
        byte_r <= bus.reg_dat_do[7:0];
      end
    end
  end

  // Transmit strobe/data held until the UART stops asserting wait.
  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      we_r        <= 1'b0;
      di_r        <= 32'h0000_0000;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= nak_s;
      if (ack_s || nak_s) begin
        we_r <= 1'b1;
        di_r <= {24'h00_0000, (ack_s ? ACK_CHAR : NAK_CHAR)};
      end else if (accept_s) begin
        we_r <= 1'b0;
        di_r <= 32'h0000_0000;
      end
    end
  end

  // Duty registers, written only when a complete frame terminates cleanly.
  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      duty_red_r   <= RESET_DUTY_R;
      duty_green_r <= RESET_DUTY_G;
      duty_blue_r  <= RESET_DUTY_B;
    end else if (commit_s) begin
      case (chan_r)
        CH_RED:   duty_red_r   <= {hi_r, lo_r};
        CH_GREEN: duty_green_r <= {hi_r, lo_r};
        CH_BLUE:  duty_blue_r  <= {hi_r, lo_r};
        default:  duty_red_r   <= duty_red_r;
      endcase
    end
  end

  assign bus.reg_dat_re = re_r;
  assign bus.reg_dat_we = we_r;
  assign bus.reg_dat_di = di_r;
  assign frame_err      = frame_err_r;

  rgb_pwm_gen #(
    .PWM_PRESCALE (PWM_PRESCALE)
  ) u_pwm (
    .hw_clk     (hw_clk),
    .resetn     (resetn),
    .duty_red   (duty_red_r),
    .duty_green (duty_green_r),
    .duty_blue  (duty_blue_r),
    .pwm_red    (pwm_red),
    .pwm_green  (pwm_green),
    .pwm_blue   (pwm_blue)
  );

endmodule

// File: tb/tb_uart_rgb_cmd_pwm.sv
// Directed bench for uart_rgb_cmd_pwm: a byte-queue model of the simpleuart
// receive buffer, a write monitor, and PWM duty measured over full periods.
module tb_uart_rgb_cmd_pwm;

  localparam int PS = 3;

  logic hw_clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_wait = 1'b0;
  logic pwm_red, pwm_green, pwm_blue, frame_err;

  logic [7:0] rx_buf [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;

  int re_cnt = 0;
  int wr_cnt = 0;
  int fe_cnt = 0;
  logic [31:0] last_di = 32'h0;

  int total = 0;
  int bad = 0;

  uart_rgb_cmd_pwm_if u_if ();

  uart_rgb_cmd_pwm #(
    .PWM_PRESCALE (PS)
  ) dut (
    .hw_clk    (hw_clk),
    .resetn    (resetn),
    .bus       (u_if),
    .pwm_red   (pwm_red),
    .pwm_green (pwm_green),
    .pwm_blue  (pwm_blue),
    .frame_err (frame_err)
  );

  always #5 hw_clk = ~hw_clk;

  assign u_if.reg_dat_do   = (rd_ptr == wr_ptr) ? 32'hFFFF_FFFF : {24'h0, rx_buf[rd_ptr]};
  assign u_if.reg_dat_wait = uart_wait;

  // UART model: consume on re; a system reset also clears the buffer.
  always @(posedge hw_clk) begin
    if (!resetn) rd_ptr <= wr_ptr;
    else if (u_if.reg_dat_re) rd_ptr <= rd_ptr + 1;
  end

  always @(posedge hw_clk) begin
    if (u_if.reg_dat_re) re_cnt <= re_cnt + 1;
    if (u_if.reg_dat_we && !u_if.reg_dat_wait) begin
      wr_cnt  <= wr_cnt + 1;
      last_di <= u_if.reg_dat_di;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_buf[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push(s[i]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge hw_clk);
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_cnt < target && n < 300) begin
      @(negedge hw_clk);
      n++;
    end
    cycles(2);
  endtask

  task automatic wait_we();
    int n = 0;
    while (!u_if.reg_dat_we && n < 300) begin
      @(negedge hw_clk);
      n++;
    end
  endtask

  // One sample per tick interval over 256 ticks = one full PWM period.
  task automatic measure(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (256) begin
      repeat (PS + 1) @(negedge hw_clk);
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
    end
  endtask

  initial begin
    int hr, hg, hb, base, stable;

    cycles(3);
    chk("rst_re", {31'h0, u_if.reg_dat_re}, 32'h0);
    chk("rst_we", {31'h0, u_if.reg_dat_we}, 32'h0);
    chk("rst_di", u_if.reg_dat_di, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_pwm", {29'h0, pwm_red, pwm_green, pwm_blue}, 32'h0);

    resetn = 1'b1;
    measure(hr, hg, hb);
    chk("idle_pwm1", hr + hg + hb, 32'd0);
    measure(hr, hg, hb);
    chk("idle_pwm2", hr + hg + hb, 32'd0);
    chk("idle_re", re_cnt, 32'd0);
    chk("idle_wr", wr_cnt, 32'd0);

    push_str("R80\n");
    wait_wr(1);
    chk("r80_di", last_di, 32'h4B);
    cycles(8);
    chk("r80_wrcnt", wr_cnt, 32'd1);
    measure(hr, hg, hb);
    chk("r80_red", hr, 32'd128);
    chk("r80_green", hg, 32'd0);

    push_str("gFf");
    push(8'h0D);
    wait_wr(2);
    chk("gff_di", last_di, 32'h4B);
    cycles(8);
    measure(hr, hg, hb);
    chk("gff_green", hg, 32'd255);
    chk("gff_red", hr, 32'd128);

    push_str("BZ");
    wait_wr(3);
    chk("bz_di", last_di, 32'h3F);
    cycles(4);
    chk("bz_ferr", fe_cnt, 32'd1);
    measure(hr, hg, hb);
    chk("bz_blue", hb, 32'd0);
    push_str("B05\n");
    wait_wr(4);
    chk("b05_di", last_di, 32'h4B);
    cycles(8);
    measure(hr, hg, hb);
    chk("b05_blue", hb, 32'd5);
    chk("b05_ferr", fe_cnt, 32'd1);

    uart_wait = 1'b1;
    push_str("G10\n");
    wait_we();
    stable = 0;
    repeat (10) begin
      if (u_if.reg_dat_we && u_if.reg_dat_di == 32'h4B) stable++;
      @(negedge hw_clk);
    end
    chk("hold_stable", stable, 32'd10);
    chk("hold_nowr", wr_cnt, 32'd4);
    uart_wait = 1'b0;
    @(negedge hw_clk);
    chk("hold_we_drop", {31'h0, u_if.reg_dat_we}, 32'h0);
    cycles(5);
    chk("hold_wrcnt", wr_cnt, 32'd5);
    chk("hold_di", last_di, 32'h4B);
    measure(hr, hg, hb);
    chk("g10_green", hg, 32'd16);

    base = re_cnt;
    push_str("R4");
    begin
      int n = 0;
      while (re_cnt < base + 1 && n < 100) begin @(negedge hw_clk); n++; end
      n = 0;
      while (!u_if.reg_dat_re && n < 100) begin @(negedge hw_clk); n++; end
    end
    chk("mid_re_seen", {31'h0, u_if.reg_dat_re}, 32'h1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_re_async", {31'h0, u_if.reg_dat_re}, 32'h0);
    chk("mid_we_async", {31'h0, u_if.reg_dat_we}, 32'h0);
    cycles(3);
    resetn = 1'b1;

    uart_wait = 1'b1;
    push_str("B77\n");
    wait_we();
    chk("send_we_up", {31'h0, u_if.reg_dat_we}, 32'h1);
    #1 resetn = 1'b0;
    #1;
    chk("send_we_async", {31'h0, u_if.reg_dat_we}, 32'h0);
    chk("send_di_async", u_if.reg_dat_di, 32'h0);
    cycles(3);
    uart_wait = 1'b0;
    resetn = 1'b1;
    cycles(2);

    base = wr_cnt;
    push_str("R40\n");
    wait_wr(base + 1);
    chk("r40_wrcnt", wr_cnt, base + 1);
    chk("r40_di", last_di, 32'h4B);
    cycles(8);
    measure(hr, hg, hb);
    chk("r40_red", hr, 32'd64);
    chk("r40_green", hg, 32'd0);
    chk("r40_blue", hb, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rgb_cmd_pwm.md
Name: uart_rgb_cmd_pwm

Overview:
- Command-decoding stage that sits between the simpleuart register interface and the SB_RGBA_DRV RGB PWM inputs.
- Polls the UART receive register and parses ASCII frames of the form `<ch><hex><hex><CR|LF>`, for example "R80\n".
- Updates an 8-bit duty register per colour and drives three PWM outputs from those registers.
- Echoes an ACK or NAK character for each completed or aborted frame.

Parameters:
- PWM_PRESCALE, 47, number of extra hw_clk cycles per PWM tick; the PWM period is (PWM_PRESCALE+1)*256 clocks, about 977 Hz at 12 MHz.
- RESET_DUTY_R, 8'h00, red duty value after reset.
- RESET_DUTY_G, 8'h00, green duty value after reset.
- RESET_DUTY_B, 8'h00, blue duty value after reset.
- ACK_CHAR, 8'h4B ("K"), byte echoed after a valid frame.
- NAK_CHAR, 8'h3F ("?"), byte echoed after an invalid frame.

Ports:
- hw_clk  in  1  system clock, 12 MHz.
- resetn  in  1  asynchronous, active-low reset.
- reg_dat_re  out  1  UART receive read strobe; consumes the buffered byte at the clock edge.
- reg_dat_do  in  32  UART receive data; 32'hFFFFFFFF when the buffer is empty, otherwise {24'b0, byte}.
- reg_dat_we  out  1  UART transmit write strobe.
- reg_dat_di  out  32  UART transmit data, {24'b0, byte}.
- reg_dat_wait  in  1  UART transmitter busy; a write is held while this is high.
- pwm_red  out  1  PWM output to RGB0PWM.
- pwm_green  out  1  PWM output to RGB2PWM.
- pwm_blue  out  1  PWM output to RGB1PWM.
- frame_err  out  1  one-cycle pulse when a NAK is queued.

Behaviour:
- Reset is asynchronous and active-low: one clock (hw_clk); resetn asserted low forces all state asynchronously.
- Values while resetn is low:
  - reg_dat_re = 0, reg_dat_we = 0, reg_dat_di = 0, frame_err = 0.
  - State = IDLE; duty registers = RESET_DUTY_*; prescaler and PWM counter = 0.
  - PWM outputs low until the first tick compare.
- Receive handshake:
  - In any receive state, if reg_dat_do != 32'hFFFFFFFF, assert reg_dat_re for exactly one cycle.
  - Sample reg_dat_do[7:0] in that same cycle.
  - Next cycle, re = 0 and the byte is processed; a byte is never read twice.
- State machine:
  - IDLE:
    - "R"/"r" → GET_HI, channel 0; "G"/"g" → GET_HI, channel 1; "B"/"b" → GET_HI, channel 2.
    - CR (0x0D) or LF (0x0A) is ignored and the state stays IDLE.
    - Any other byte → SEND with NAK.
  - GET_HI: a hex digit (0-9, A-F, a-f) is stored as the upper nibble → GET_LO; anything else → SEND with NAK.
  - GET_LO: a hex digit is stored as the lower nibble → GET_TERM; anything else → SEND with NAK.
  - GET_TERM:
    - CR or LF: commit {hi, lo} to the selected duty register on that cycle → SEND with ACK.
    - Anything else → SEND with NAK and no commit.
  - SEND:
    - Drive reg_dat_di = {24'b0, char} and reg_dat_we = 1.
    - Hold both while reg_dat_wait = 1.
    - In the first cycle with we = 1 and wait = 0, the write is accepted; next cycle we = 0 and the state returns to IDLE.
    - No receive reads occur in SEND.
- frame_err pulses in the cycle the state enters SEND with NAK.
- Bytes arriving during SEND stay in the simpleuart buffer; overrun loss is accepted.
- PWM generation:
  - The prescaler counts 0..PWM_PRESCALE and wraps; the wrap cycle is a tick.
  - On a tick, an 8-bit counter increments modulo 256 (255 → 0 wrap).
  - pwm_x is registered as (counter < duty_x).
  - Duty 0 means always low; duty 255 gives a 255/256 high ratio.
- Duty updates take effect at the next compare; there is no glitch-free period alignment requirement.
- A commit on the same cycle as a tick uses the old duty for that compare.
- Reset asserted mid-frame or mid-send aborts immediately: no partial commit, and we drops asynchronously.

Decomposition:
- Package uart_rgb_cmd_pkg:
  - State enum: IDLE, GET_HI, GET_LO, GET_TERM, SEND.
  - ASCII constants: CR, LF, R/G/B upper and lower case.
  - UART_EMPTY = 32'hFFFFFFFF.
  - Channel index constants.
  - hex_to_nibble / is_hex functions.
- Sub-module rgb_pwm_gen (hw_clk, resetn, three duty inputs, three PWM outputs): contains the prescaler, counter and comparators.
- The parser FSM stays in the top block.

Test Plan:
- Reset then idle (do = FFFFFFFF): re stays 0, we stays 0, and pwm_red/green/blue stay 0 across 2 PWM periods.
- Bytes "R","8","0","\n": duty_r = 0x80; pwm_red is high for 128 of 256 ticks; exactly one write with di = 0x4B.
- Bytes "g","F","f","\r": duty_g = 0xFF; pwm_green is low for exactly one tick per period; ACK is echoed.
- Bytes "B","Z": NAK 0x3F is written; frame_err pulses once; duty_b is unchanged; a following "B05\n" is accepted with duty_b = 5.
- ACK with reg_dat_wait held high for 10 cycles: we and di = 0x4B are held stable for all 10 cycles; we drops one cycle after wait falls; a single write occurs.
- resetn pulsed low between "R","4": re and we drop immediately; duty_r = RESET_DUTY_R; the next "R40\n" parses from IDLE correctly.
